regfile_ifc: RTL and testbench
==============================

Name: regfile_ifc

Overview:
Parametrised successor to the team's 8-entry, 1-bit write/read interface block. Generalised in data width and depth, with the same enable/ready handshake per method. Adds a registered read response with a valid strobe, a hardware zero-initialisation sweep after reset or on request, and defined same-cycle read/write hazard behaviour. Sits behind the same style of cocotb wrapper as the existing DUT.

Parameters:
DATA_W, 1, width of each storage entry in bits (>=1)
DEPTH, 8, number of entries (>=2; need not be a power of two)
ADDR_W (localparam), $clog2(DEPTH), address width; not overridable

Ports:
CLK  in  1  single clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
write_address  in  ADDR_W  write target entry
write_data  in  DATA_W  write value
write_en  in  1  write request; accepted only when write_rdy=1
write_rdy  out  1  write method ready
read_address  in  ADDR_W  read target entry
read_en  in  1  read request; accepted only when read_rdy=1
read_data  out  DATA_W  registered read result
read_valid  out  1  one-cycle strobe: read_data updated this cycle
read_rdy  out  1  read method ready
clear_en  in  1  request re-initialisation of all entries to 0
init_busy  out  1  high while the zeroing sweep runs

Behaviour:
- Reset (asynchronous, any time, including mid-sweep or mid-read):
  - state goes to INIT, sweep index = 0.
  - Output values during reset: write_rdy=0, read_rdy=0, read_valid=0, read_data=0, init_busy=1.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes 0 to entry[idx], then idx++.
  - On the cycle idx==DEPTH-1 is written, the next state is READY.
  - The sweep takes exactly DEPTH cycles after reset deasserts.
  - write_en, read_en and clear_en are ignored; rdy outputs are 0; init_busy=1.
- READY:
  - write_rdy=1, read_rdy=1, init_busy=0.
  - clear_en=1 moves the FSM to INIT with idx=0. clear has priority: any write_en/read_en in that same cycle is dropped, and read_valid is 0 next cycle.
- Write: write_en & write_rdy at edge N stores write_data to entry[write_address]; the entry holds the new value from cycle N+1.
- Read:
  - read_en & read_rdy at edge N loads read_data and sets read_valid=1 during cycle N+1 (latency 1).
  - read_valid drops the following cycle unless another read is accepted. Back-to-back reads give a strobe every cycle.
  - read_data holds its last value when read_valid=0.
- Out-of-range address (>= DEPTH, possible only when DEPTH is not a power of two):
  - write is discarded.
  - read is still accepted and returns 0 with read_valid=1.
- Simultaneous write and read to the same address in one cycle: returns the old (pre-write) contents, unless REGFILE_BYPASS_EN is defined (see below).
- Simultaneous write and read to different addresses: both proceed independently.
- No backpressure on the read response; the consumer must sample read_data when read_valid=1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-first. A same-cycle, same-address read returns write_data, so read_data shows the new value at N+1. Out-of-range addresses still return 0.
- Undefined: read-first, returning the old value as described above.
- Storage and all other timing are identical in both builds.

Decomposition:
- regfile_pkg holds:
  - FSM state enum (ST_INIT, ST_READY).
  - Default DATA_W/DEPTH constants.
  - Function computing ADDR_W.
- Sub-module regfile_init_seq: holds the INIT/READY FSM and the sweep counter; outputs init_busy, sweep index and sweep write-enable.
- The top level holds the storage array, the write/read muxing and the read response register.

Test Plan:
- Reset release -> init_busy=1 and rdy=0 for exactly 8 cycles (defaults); every entry then reads 0 with read_valid=1 one cycle after each read_en.
- Write address 5 = 1, then read address 5 -> read_data=1 with read_valid=1 at N+1. Read address 4 -> 0.
- DATA_W=8, DEPTH=6, two builds:
  - write address 7 = 0xAA -> discarded; read address 7 -> 0x00, valid.
  - write address 5 = 0x3C -> read address 5 returns 0x3C.
- Preload address 2 = 0, then same-cycle write 2 = 1 and read 2:
  - without the macro -> read_data=0.
  - with REGFILE_BYPASS_EN -> read_data=1.
  - the cycle after, a read of address 2 returns 1 in both builds.
- Fill entries 0..7 with 1, then pulse clear_en together with write_en on address 3 -> write dropped, init_busy=1 for 8 cycles, all entries then read 0.
- Assert RST during the 4th sweep cycle and during a pending read_valid -> read_valid and read_data go to 0 immediately; the full 8-cycle sweep restarts after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and address-width helper for the regfile_ifc block.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 1;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // A depth of 1 would give a zero-width address; clamp to one bit.
  function automatic int addr_w_for(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Zeroing-sweep sequencer: walks every entry once after reset or a clear request,
// then parks in READY until the next clear.
//
// state    | meaning
// ST_INIT  | sweep in progress, one entry zeroed per cycle, host methods blocked
// ST_READY | storage usable, read/write methods accepted
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_w_for(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear_en,
  output logic              init_busy,
  output logic [ADDR_W-1:0] sweep_idx,
  output logic              sweep_we
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_idx == LAST_IDX) begin
            state     <= ST_READY;
            sweep_idx <= '0;
            init_busy <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (clear_en) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          sweep_idx <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // The sweep writes on every INIT cycle, including while reset is held.
  assign sweep_we = init_busy;

endmodule

// File: rtl/regfile_ifc.sv
// Parametrised register file with enable/ready write and read methods, a registered
// read response and a zeroing sweep. Optional macro REGFILE_BYPASS_EN: write-first
// same-address reads (default build is read-first).
module regfile_ifc
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = addr_w_for(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              read_rdy,
  input  logic              clear_en,
  output logic              init_busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sweep_idx;
  logic              sweep_we;
  logic              host_ok;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;

  regfile_init_seq #(.DEPTH(DEPTH)) u_init_seq (
    .CLK       (CLK),
    .RST       (RST),
    .clear_en  (clear_en),
    .init_busy (init_busy),
    .sweep_idx (sweep_idx),
    .sweep_we  (sweep_we)
  );

  assign write_rdy = ~init_busy;
  assign read_rdy  = ~init_busy;

  // A clear in the same cycle wins over both host methods.
  assign host_ok     = ~init_busy & ~clear_en;
  assign wr_in_range = 32'(write_address) < DEPTH;
  assign rd_in_range = 32'(read_address) < DEPTH;
  assign wr_ok       = write_en & host_ok & wr_in_range;
  assign rd_ok       = read_en & host_ok;

  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_ok) begin
      mem[write_address] <= write_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_address];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (write_address == read_address)) begin
        rd_word = write_data;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      read_valid <= rd_ok;
      if (rd_ok) begin
        read_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ifc.sv
// Bench for regfile_ifc: a default 1x8 instance and an 8x6 instance side by side,
// compared every cycle against an array-based reference model.
module tb_regfile_ifc;

  localparam int DEP_A = 8;
  localparam int DEP_B = 6;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       we [2];
  logic       re [2];
  logic       clr[2];
  logic [2:0] wa [2];
  logic [2:0] ra [2];
  logic [7:0] wd [2];

  logic       a_wrdy, a_rrdy, a_vld, a_busy;
  logic [0:0] a_rd;
  logic       b_wrdy, b_rrdy, b_vld, b_busy;
  logic [7:0] b_rd;

  regfile_ifc #(.DATA_W(1), .DEPTH(DEP_A)) dut_a (
    .CLK(clk), .RST(rst),
    .write_address(wa[0]), .write_data(wd[0][0:0]), .write_en(we[0]), .write_rdy(a_wrdy),
    .read_address(ra[0]), .read_en(re[0]), .read_data(a_rd), .read_valid(a_vld),
    .read_rdy(a_rrdy), .clear_en(clr[0]), .init_busy(a_busy)
  );

  regfile_ifc #(.DATA_W(8), .DEPTH(DEP_B)) dut_b (
    .CLK(clk), .RST(rst),
    .write_address(wa[1]), .write_data(wd[1]), .write_en(we[1]), .write_rdy(b_wrdy),
    .read_address(ra[1]), .read_en(re[1]), .read_data(b_rd), .read_valid(b_vld),
    .read_rdy(b_rrdy), .clear_en(clr[1]), .init_busy(b_busy)
  );

  // Reference model: contents, remaining sweep cycles, expected response.
  logic [7:0] m_mem [2][8];
  int         m_busy[2];
  logic       m_vld [2];
  logic [7:0] m_dat [2];

  int errors = 0;
  int checks = 0;

  function automatic int dep(input int d);
    return (d == 0) ? DEP_A : DEP_B;
  endfunction

  function automatic logic [7:0] msk(input int d);
    return (d == 0) ? 8'h01 : 8'hFF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = dep(d);
      m_vld[d]  = 1'b0;
      m_dat[d]  = 8'h00;
      for (int i = 0; i < 8; i++) m_mem[d][i] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] > 0) begin
        m_busy[d]--;
        m_vld[d] = 1'b0;
      end else if (clr[d]) begin
        m_busy[d] = dep(d);
        m_vld[d]  = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[d][i] = 8'h00;
      end else begin
        m_vld[d] = re[d];
        if (re[d]) begin
          if (int'(ra[d]) >= dep(d)) m_dat[d] = 8'h00;
          else if (BYPASS && we[d] && wa[d] == ra[d]) m_dat[d] = wd[d] & msk(d);
          else m_dat[d] = m_mem[d][ra[d]];
        end
        if (we[d] && int'(wa[d]) < dep(d)) m_mem[d][wa[d]] = wd[d] & msk(d);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_read_valid", {7'd0, a_vld},  {7'd0, m_vld[0]});
    chk("a_read_data",  {7'd0, a_rd},   m_dat[0]);
    chk("a_init_busy",  {7'd0, a_busy}, {7'd0, m_busy[0] > 0});
    chk("a_write_rdy",  {7'd0, a_wrdy}, {7'd0, m_busy[0] == 0});
    chk("a_read_rdy",   {7'd0, a_rrdy}, {7'd0, m_busy[0] == 0});
    chk("b_read_valid", {7'd0, b_vld},  {7'd0, m_vld[1]});
    chk("b_read_data",  b_rd,           m_dat[1]);
    chk("b_init_busy",  {7'd0, b_busy}, {7'd0, m_busy[1] > 0});
    chk("b_write_rdy",  {7'd0, b_wrdy}, {7'd0, m_busy[1] == 0});
    chk("b_read_rdy",   {7'd0, b_rrdy}, {7'd0, m_busy[1] == 0});
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b0; re[d] = 1'b0; clr[d] = 1'b0;
      wa[d] = 3'd0; ra[d] = 3'd0; wd[d] = 8'h00;
    end
  endtask

  // Model the edge from inputs held stable since the last edge, then sample at +1.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [7:0] v);
    we[d] = 1'b1; wa[d] = a; wd[d] = v;
  endtask

  task automatic rd(input int d, input logic [2:0] a);
    re[d] = 1'b1; ra[d] = a;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sweep after reset: busy for DEPTH cycles in each instance.
    repeat (DEP_A) tick();

    // Every entry reads zero; B also covers out-of-range 6 and 7.
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i)); rd(1, 3'(i));
      tick();
    end
    tick();

    // Write 5 then read 5 and 4.
    wr(0, 3'd5, 8'h01); wr(1, 3'd7, 8'hAA); tick();
    rd(0, 3'd5); rd(1, 3'd7); tick();
    rd(0, 3'd4); wr(1, 3'd5, 8'h3C); tick();
    rd(1, 3'd5); tick();
    tick();

    // Same-cycle write/read of address 2 after preloading 0.
    wr(0, 3'd2, 8'h00); wr(1, 3'd2, 8'h00); tick();
    wr(0, 3'd2, 8'h01); rd(0, 3'd2); wr(1, 3'd2, 8'h01); rd(1, 3'd2); tick();
    rd(0, 3'd2); rd(1, 3'd2); tick();
    tick();

    // Fill with ones, then clear with a competing write.
    for (int i = 0; i < 8; i++) begin
      wr(0, 3'(i), 8'h01); wr(1, 3'(i), 8'hFF);
      tick();
    end
    clr[0] = 1'b1; wr(0, 3'd3, 8'h01); rd(0, 3'd3);
    clr[1] = 1'b1; wr(1, 3'd3, 8'h55);
    tick();
    repeat (DEP_A) tick();
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i)); rd(1, 3'(i));
      tick();
    end

    // Reset in A's 4th sweep cycle while B has a read response pending.
    for (int i = 0; i < 8; i++) begin
      wr(0, 3'(i), 8'h01);
      tick();
    end
    clr[0] = 1'b1; rd(1, 3'd1); tick();
    rd(1, 3'd2); tick();
    rd(1, 3'd3); tick();
    rd(1, 3'd4); tick();
    rd(1, 3'd5);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    idle();
    rst = 1'b0;
    repeat (DEP_A) tick();
    for (int i = 0; i < 8; i++) begin
      rd(0, 3'(i)); rd(1, 3'(i));
      tick();
    end

    // Randomised traffic with occasional clears and forced same-address collisions.
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        we[d]  = 1'($urandom_range(0, 1));
        wa[d]  = 3'($urandom_range(0, 7));
        wd[d]  = 8'($urandom);
        re[d]  = 1'($urandom_range(0, 1));
        ra[d]  = ($urandom_range(0, 3) == 0) ? wa[d] : 3'($urandom_range(0, 7));
        clr[d] = ($urandom_range(0, 60) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
